// File: rtl/mem_param.sv
// Parametrised single-port RAM with registered read handshake and a sweep-to-FILL clear engine.
// Define MEM_PARAM_OUTREG_EN to add a second output pipeline stage (read latency 2 instead of 1).
module mem_param #(
  parameter int            DW   = 8,
  parameter int            AW   = 10,
  parameter logic [DW-1:0] FILL = '0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  output logic          o_busy,
  input  logic          i_wr,
  input  logic          i_rd,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_d_i,
  output logic [DW-1:0] o_d_o,
  output logic          o_d_o_vld
);

  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_ptr;
  logic          r_busy;
  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rd_data;
  logic          r_rd_vld;

  logic          w_idle;
  logic          w_start;
  logic          w_access;
  logic          w_last;
  logic          w_wr_en;
  logic [AW-1:0] w_wr_addr;
  logic [DW-1:0] w_wr_data;
  logic          w_rd_en;

  // A clear request on an idle edge takes priority and swallows any access on that edge.
  assign w_idle    = (r_state == S_IDLE);
  assign w_start   = w_idle & i_clr;
  assign w_access  = w_idle & ~i_clr;
  assign w_last    = (r_ptr == {AW{1'b1}});
  assign w_wr_en   = (r_state == S_CLEAR) | (w_access & i_wr);
  assign w_wr_addr = (r_state == S_CLEAR) ? r_ptr : i_addr;
  assign w_wr_data = (r_state == S_CLEAR) ? FILL : i_d_i;
  assign w_rd_en   = w_access & i_rd;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_CLEAR;
      r_ptr   <= '0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_clr) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_ptr <= r_ptr + 1'b1;
          if (w_last) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_CLEAR;
          r_ptr   <= '0;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // The array itself has no reset; the sweep initialises it.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  // Reading the array here alongside the write block yields old data on a same-address collision.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_data <= '0;
      r_rd_vld  <= 1'b0;
    end else begin
      r_rd_vld <= w_rd_en;
      if (w_rd_en) begin
        r_rd_data <= r_mem[i_addr];
      end
    end
  end

`ifdef MEM_PARAM_OUTREG_EN
  logic [DW-1:0] r_out_data;
  logic          r_out_vld;

  // The start of a sweep flushes any read still in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out_data <= '0;
      r_out_vld  <= 1'b0;
    end else if (w_start) begin
      r_out_vld <= 1'b0;
    end else begin
      r_out_vld <= r_rd_vld;
      if (r_rd_vld) begin
        r_out_data <= r_rd_data;
      end
    end
  end

  assign o_d_o     = r_out_data;
  assign o_d_o_vld = r_out_vld;
`else
  assign o_d_o     = r_rd_data;
  assign o_d_o_vld = r_rd_vld;
`endif

  assign o_busy = r_busy;

endmodule

// File: tb/tb_mem_param.sv
// Directed bench for mem_param (DW=8, AW=4, FILL=A5) with a read-data scoreboard.
module tb_mem_param;

  localparam int           AW    = 4;
  localparam int           DEPTH = 16;
  localparam logic [7:0]   FILL  = 8'hA5;
`ifdef MEM_PARAM_OUTREG_EN
  localparam int           LAT   = 2;
`else
  localparam int           LAT   = 1;
`endif

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  logic          clk = 1'b0;
  logic          rstN;
  logic          clr;
  logic          wr;
  logic          rd;
  logic [AW-1:0] addr;
  logic [7:0]    dIn;
  logic          busy;
  logic [7:0]    dOut;
  logic          dOutVld;

  exp_t       sb[$];
  logic [7:0] mdl [DEPTH];
  bit         mdlIdle = 1'b0;
  int         cyc = 0;
  int         passCount = 0;
  int         failCount = 0;
  int         checkCount = 0;

  mem_param #(.DW(8), .AW(AW), .FILL(FILL)) dut (
    .i_clk(clk),
    .i_rst_n(rstN),
    .i_clr(clr),
    .o_busy(busy),
    .i_wr(wr),
    .i_rd(rd),
    .i_addr(addr),
    .i_d_i(dIn),
    .o_d_o(dOut),
    .o_d_o_vld(dOutVld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    assert (obs === expv) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model.
  task automatic applyStimulus(input bit w, input bit r, input bit c,
                               input logic [AW-1:0] a, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    wr = w; rd = r; clr = c; addr = a; dIn = d;
    if (mdlIdle) begin
      if (c) begin
        mdlIdle = 1'b0;
        for (int i = 0; i < DEPTH; i++) mdl[i] = FILL;
      end else begin
        if (r) begin
          e.data = mdl[a];
          e.due  = cyc + LAT;
          sb.push_back(e);
        end
        if (w) mdl[a] = d;
      end
    end
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, 8'h00);
  endtask

  task automatic countBusy(input string tag, input int expected, input bit disturb);
    int n = 0;
    do begin
      if (disturb) begin
        wr = 1'b1; rd = 1'b1; addr = 4'd2; dIn = 8'h5A;
      end
      @(posedge clk);
      #1;
      wr = 1'b0; rd = 1'b0;
      n++;
    end while (busy === 1'b1 && n < 100);
    checkOutput(tag, n, expected);
    mdlIdle = 1'b1;
  endtask

  task automatic startClear(input string tag, input bit w, input bit r, input logic [AW-1:0] a);
    applyStimulus(w, r, 1'b1, a, 8'hEE);
    @(posedge clk);
    #1;
    clr = 1'b0; wr = 1'b0; rd = 1'b0;
    checkOutput(tag, busy, 1'b1);
  endtask

  task automatic readAll();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b1, 1'b0, i[AW-1:0], 8'h00);
    idleCycle();
    idleCycle();
  endtask

  // Scoreboard: every valid strobe must match the oldest expected read, at its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (dOutVld === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_vld", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("rd_data", dOut, e.data);
        checkOutput("rd_latency", cyc, e.due);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc) begin
      checkOutput("missing_vld", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
  end

  initial begin
    rstN = 1'b0; clr = 1'b0; wr = 1'b0; rd = 1'b0; addr = '0; dIn = '0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = FILL;

    repeat (3) @(negedge clk);
    checkOutput("reset_busy", busy, 1'b1);
    checkOutput("reset_vld", dOutVld, 1'b0);
    checkOutput("reset_d_o", dOut, 8'h00);

    @(negedge clk);
    rstN = 1'b1;
    countBusy("reset_sweep_len", 16, 1'b0);
    readAll();

    applyStimulus(1'b1, 1'b0, 1'b0, 4'd7, 8'h3C);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd7, 8'h00);
    idleCycle();
    idleCycle();

    applyStimulus(1'b1, 1'b0, 1'b0, 4'd5, 8'h11);
    applyStimulus(1'b1, 1'b1, 1'b0, 4'd5, 8'h22);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd5, 8'h00);
    idleCycle();
    idleCycle();

    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b0, 1'b0, i[AW-1:0], i[7:0]);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd12, 8'h00);
    idleCycle();
    idleCycle();
    startClear("clr_busy_rise", 1'b1, 1'b1, 4'd3);
    countBusy("clr_sweep_len", 16, 1'b0);
    readAll();

    startClear("clr2_busy_rise", 1'b0, 1'b0, 4'd0);
    countBusy("busy_access_len", 16, 1'b1);
    checkOutput("busy_d_o_hold", dOut, FILL);
    applyStimulus(1'b0, 1'b1, 1'b0, 4'd2, 8'h00);
    idleCycle();
    idleCycle();

    startClear("clr3_busy_rise", 1'b0, 1'b0, 4'd0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("midreset_busy", busy, 1'b1);
    checkOutput("midreset_d_o", dOut, 8'h00);
    checkOutput("midreset_vld", dOutVld, 1'b0);
    @(negedge clk);
    rstN = 1'b1;
    countBusy("midreset_sweep_len", 16, 1'b0);
    readAll();

    repeat (4) idleCycle();
    checkOutput("sb_drain", sb.size(), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
